// File: rtl/memory_unit.sv
// Main-memory responder: 2**ADDR_W word array with wait states and busy/ready handshake.
// Optional parity protection is enabled with `define MEM_PARITY_EN.
module memory_unit #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ar_outdata,
    input  logic [DATA_W-1:0] bus_indata,
    input  logic              mem_read,
    input  logic              mem_write,
`ifdef MEM_PARITY_EN
    input  logic              par_inject,
`endif
    output logic [DATA_W-1:0] mem_outdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic              mem_err
);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              rd_bad;

    assign rd_word = mem[addr_q];

`ifdef MEM_PARITY_EN
    logic inj_q;

    // Stored bit keeps the whole word at even parity unless injected.
    assign wr_word = {(^data_q) ^ inj_q, data_q};
    assign rd_bad  = ^rd_word;
`else
    assign wr_word = data_q;
    assign rd_bad  = 1'b0;
`endif

    // Array is never reset; only an ACCESS edge commits a write.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && wr_q) begin
            mem[addr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            mem_outdata <= '0;
            mem_busy    <= 1'b0;
            mem_ready   <= 1'b0;
            mem_err     <= 1'b0;
`ifdef MEM_PARITY_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    if (mem_read && mem_write) begin
                        mem_err <= 1'b1;
                    end else if (mem_read || mem_write) begin
                        addr_q   <= ar_outdata;
                        data_q   <= bus_indata;
                        wr_q     <= mem_write;
                        mem_busy <= 1'b1;
                        cnt      <= WS;
`ifdef MEM_PARITY_EN
                        inj_q    <= par_inject;
`endif
                        state    <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!wr_q) begin
                        mem_outdata <= rd_word[DATA_W-1:0];
                        mem_err     <= rd_bad;
                    end
                    mem_ready <= 1'b1;
                    mem_busy  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit with WAIT_STATES=2 and a read-data scoreboard.
// Define MEM_PARITY_EN for both files to exercise the parity path.
module tb_memory_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ar_outdata = '0;
    logic [15:0] bus_indata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
`ifdef MEM_PARITY_EN
    logic        par_inject = 1'b0;
`endif
    logic [15:0] mem_outdata;
    logic        mem_busy;
    logic        mem_ready;
    logic        mem_err;

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb[$];
    bit          ok;
    int          busy_n;

    memory_unit #(
        .ADDR_W(12),
        .DATA_W(16),
        .WAIT_STATES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ar_outdata(ar_outdata),
        .bus_indata(bus_indata),
        .mem_read(mem_read),
        .mem_write(mem_write),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .mem_outdata(mem_outdata),
        .mem_busy(mem_busy),
        .mem_ready(mem_ready),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, output bit rdy,
                              output int nbusy);
        rdy   = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_ready) begin
                rdy = 1'b1;
                break;
            end
            if (mem_busy) nbusy++;
            tick();
        end
        check({tag, "_ready_seen"}, 32'(rdy), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_data"}, 32'(mem_outdata), 32'(exp));
        end
    endtask

    task automatic txn(input string tag, input logic wr,
                       input logic [11:0] a, input logic [15:0] d);
        mem_write  = wr;
        mem_read   = !wr;
        ar_outdata = a;
        bus_indata = d;
        if (!wr) sb.push_back(d);
        tick();
        check({tag, "_busy_cap"}, 32'(mem_busy), 32'd1);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ar_outdata = ~a;
        bus_indata = 16'hDEAD;
        wait_ready(tag, ok, busy_n);
        if (ok) begin
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'd3);
            check({tag, "_busy_done"}, 32'(mem_busy), 32'd0);
            check({tag, "_err"}, 32'(mem_err), 32'd0);
            if (!wr) pop_check(tag);
        end
        tick();
        check({tag, "_ready_pulse"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_outdata", 32'(mem_outdata), 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        #10 reset = 1'b1;
        tick();

        txn("wr010", 1'b1, 12'h010, 16'hA5A5);
        txn("rd010", 1'b0, 12'h010, 16'hA5A5);
        txn("wr011", 1'b1, 12'h011, 16'h5A5A);

        // Held read: AR moves during the first transaction's WAIT.
        mem_read   = 1'b1;
        ar_outdata = 12'h010;
        sb.push_back(16'hA5A5);
        tick();
        ar_outdata = 12'h011;
        sb.push_back(16'h5A5A);
        wait_ready("held1", ok, busy_n);
        if (ok) pop_check("held1");
        tick();
        check("held2_ready_low", 32'(mem_ready), 32'd0);
        check("held2_busy", 32'(mem_busy), 32'd1);
        wait_ready("held2", ok, busy_n);
        mem_read = 1'b0;
        if (ok) pop_check("held2");
        tick();

        mem_read   = 1'b1;
        mem_write  = 1'b1;
        ar_outdata = 12'h010;
        bus_indata = 16'hFFFF;
        tick();
        check("conf_err", 32'(mem_err), 32'd1);
        check("conf_busy", 32'(mem_busy), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        check("conf_err_clr", 32'(mem_err), 32'd0);
        check("conf_busy2", 32'(mem_busy), 32'd0);
        txn("rd010_after_conf", 1'b0, 12'h010, 16'hA5A5);

        txn("wrFFF", 1'b1, 12'hFFF, 16'h0F0F);
        txn("rdFFF", 1'b0, 12'hFFF, 16'h0F0F);
        txn("rd000", 1'b0, 12'h000, 16'h0000 | (sb.size() == 0 ? 16'h0 : 16'h0));

        txn("wr020_init", 1'b1, 12'h020, 16'h0000);
        txn("rd011", 1'b0, 12'h011, 16'h5A5A);
        mem_write  = 1'b1;
        ar_outdata = 12'h020;
        bus_indata = 16'h1234;
        tick();
        mem_write = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_outdata", 32'(mem_outdata), 32'd0);
        check("mid_rst_busy", 32'(mem_busy), 32'd0);
        check("mid_rst_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_err", 32'(mem_err), 32'd0);
        #2 reset = 1'b1;
        tick();
        check("post_rst_busy", 32'(mem_busy), 32'd0);
        txn("rd020", 1'b0, 12'h020, 16'h0000);

`ifdef MEM_PARITY_EN
        par_inject = 1'b1;
        txn("wr_par", 1'b1, 12'h030, 16'h00FF);
        par_inject = 1'b0;
        mem_read   = 1'b1;
        ar_outdata = 12'h030;
        sb.push_back(16'h00FF);
        tick();
        mem_read = 1'b0;
        wait_ready("rd_par", ok, busy_n);
        if (ok) begin
            check("rd_par_err", 32'(mem_err), 32'd1);
            pop_check("rd_par");
        end
        tick();
        check("rd_par_err_clr", 32'(mem_err), 32'd0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
